// File: rtl/idu_issue_queue.sv
// Instruction issue queue: circular FIFO of fetched instructions with head
// decode, register-file/forwarding operand select and a busy-bit scoreboard
// that holds the head back while a source register is still in flight.

// Operand select for one source register: x0 reads zero, otherwise the
// lowest-index matching forward channel wins, otherwise the register file.
module idu_iq_opsel #(
    parameter int XLEN = 32,
    parameter int RAW  = 4,
    parameter int NFWD = 2
) (
    input  logic [RAW-1:0]       rs,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*RAW-1:0]  fwd_rd,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [XLEN-1:0]      rf_rdata,
    output logic [XLEN-1:0]      val,
    output logic                 hit
);
    // Scan from the highest channel down so the lowest match is written last.
    always_comb begin
        hit = 1'b0;
        val = rf_rdata;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_rd[i*RAW +: RAW] == rs)) begin
                hit = 1'b1;
                val = fwd_data[i*XLEN +: XLEN];
            end
        end
        if (rs == '0) val = '0;
    end
endmodule

module idu_issue_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int NREG  = 16,
    parameter int NFWD  = 2,
    localparam int RAW  = $clog2(NREG),
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [XLEN-1:0]      in_pc,
    input  logic                 in_spec,
    input  logic                 flush,
    output logic [RAW-1:0]       rf_raddr1,
    output logic [RAW-1:0]       rf_raddr2,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*RAW-1:0]  fwd_rd,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 wb_valid,
    input  logic [RAW-1:0]       wb_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [XLEN-1:0]      out_pc,
    output logic                 out_spec,
    output logic [XLEN-1:0]      out_rs1v,
    output logic [XLEN-1:0]      out_rs2v,
    output logic [RAW-1:0]       out_rd,
    output logic                 out_rd_wen,
    output logic                 hazard,
    output logic [CW-1:0]        count
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [DEPTH-1:0][31:0]      q_inst;
    logic [DEPTH-1:0][XLEN-1:0]  q_pc;
    logic [DEPTH-1:0]            q_spec;
    logic [PW-1:0]               head, tail;
    logic [CW-1:0]               cnt;
    logic [NREG-1:0]             busy, busy_nxt;

    logic [31:0]                 h_inst;
    logic [6:0]                  opc;
    logic                        use_rs1, use_rs2, wen_op;
    logic                        nonempty, enq, issue;
    logic [1:0][RAW-1:0]         src_rs;
    logic [1:0][XLEN-1:0]        src_rf, src_val;
    logic [1:0]                  src_hit;

    assign h_inst    = q_inst[head];
    assign opc       = h_inst[6:0];
    assign src_rs[0] = h_inst[15 +: RAW];
    assign src_rs[1] = h_inst[20 +: RAW];
    assign src_rf[0] = rf_rdata1;
    assign src_rf[1] = rf_rdata2;

    // Head decode: which sources are read and whether rd is written.
    always_comb begin
        use_rs1 = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
        use_rs2 = (opc == OP_BRANCH || opc == OP_STORE || opc == OP_OP);
        wen_op  = (opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL ||
                   opc == OP_JALR || opc == OP_LOAD || opc == OP_IMM ||
                   opc == OP_OP) ||
                  (opc == OP_SYSTEM && h_inst[14:12] != 3'b000);
    end

    for (genvar g = 0; g < 2; g++) begin : g_src
        idu_iq_opsel #(.XLEN(XLEN), .RAW(RAW), .NFWD(NFWD)) u_opsel (
            .rs       (src_rs[g]),
            .fwd_valid(fwd_valid),
            .fwd_rd   (fwd_rd),
            .fwd_data (fwd_data),
            .rf_rdata (src_rf[g]),
            .val      (src_val[g]),
            .hit      (src_hit[g])
        );
    end

    assign nonempty   = (cnt != '0);
    assign in_ready   = !rst && !flush && (cnt < CW'(DEPTH));
    assign enq        = in_valid && in_ready;
    assign hazard     = !rst && nonempty &&
                        ((use_rs1 && busy[src_rs[0]] && !src_hit[0]) ||
                         (use_rs2 && busy[src_rs[1]] && !src_hit[1]));
    assign out_valid  = !rst && nonempty && !hazard && !flush;
    assign issue      = out_valid && out_ready;

    assign rf_raddr1  = src_rs[0];
    assign rf_raddr2  = src_rs[1];
    assign out_inst   = h_inst;
    assign out_pc     = q_pc[head];
    assign out_spec   = q_spec[head];
    assign out_rs1v   = src_val[0];
    assign out_rs2v   = src_val[1];
    assign out_rd     = h_inst[7 +: RAW];
    assign out_rd_wen = wen_op && (out_rd != '0);
    assign count      = cnt;

    // Scoreboard next state: writeback clears, issue sets (set wins), x0 idle.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid) busy_nxt[wb_rd] = 1'b0;
        if (issue && out_rd_wen) busy_nxt[out_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    // FIFO storage, pointers and occupancy; pointers wrap naturally (DEPTH=2^PW).
    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            q_inst <= '0;
            q_pc   <= '0;
            q_spec <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (enq) begin
                q_inst[tail] <= in_inst;
                q_pc[tail]   <= in_pc;
                q_spec[tail] <= in_spec;
                tail         <= tail + PW'(1);
            end
            if (issue) head <= head + PW'(1);
            case ({enq, issue})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: doc/idu_issue_queue.md
IDU_ISSUE_QUEUE -- requirements
Module: ysyx_idu_issue_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/PC width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-003 SHALL have parameter NREG, default 16, architectural registers (16 = RV32E, 32 = RV32I); RAW = log2(NREG).
REQ-004 SHALL have parameter NFWD, default 2, forwarding channels.
REQ-005 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-006 Ports: clk in 1; rst in 1.
REQ-007 Ports: in_valid in 1; in_ready out 1; in_inst in 32; in_pc in XLEN; in_spec in 1 (speculative fetch flag).
REQ-008 Ports: flush in 1, drop all queued entries.
REQ-009 Ports: rf_raddr1, rf_raddr2 out RAW; rf_rdata1, rf_rdata2 in XLEN (same-cycle read).
REQ-010 Ports: fwd_valid in NFWD; fwd_rd in NFWD*RAW; fwd_data in NFWD*XLEN.
REQ-011 Ports: wb_valid in 1; wb_rd in RAW (scoreboard clear).
REQ-012 Ports: out_valid out 1; out_ready in 1; out_inst out 32; out_pc out XLEN; out_spec out 1; out_rs1v, out_rs2v out XLEN; out_rd out RAW; out_rd_wen out 1.
REQ-013 Ports: hazard out 1; count out log2(DEPTH)+1.

Function
REQ-014 Queue SHALL be circular FIFO; enqueue when in_valid & in_ready; in_ready = (count < DEPTH) & !flush.
REQ-015 Head fields SHALL decode combinationally: rs1 = inst[15+RAW-1:15], rs2 = inst[20+RAW-1:20], rd = inst[7+RAW-1:7]; upper register-index bits ignored when NREG=16.
REQ-016 rs1 used unless opcode in {LUI, AUIPC, JAL}; rs2 used only for opcode in {B-type, S-type, R-type}.
REQ-017 out_rd_wen = 1 for {LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP}, and SYSTEM with funct3 != 0; 0 when rd = 0.
REQ-018 rf_raddr1/2 SHALL equal head rs1/rs2 whenever queue non-empty.
REQ-019 Operand select per source: x0 -> 0; else lowest-index channel i with fwd_valid[i] & fwd_rd[i]==rs -> fwd_data[i]; else rf_rdata.
REQ-020 Scoreboard: NREG busy bits; x0 never busy.
REQ-021 hazard = non-empty & (used rs1 busy & not forwarded | used rs2 busy & not forwarded).
REQ-022 out_valid = non-empty & !hazard & !flush; issue = out_valid & out_ready.
REQ-023 Issue SHALL dequeue head and, if out_rd_wen, set busy[rd] next cycle.
REQ-024 wb_valid SHALL clear busy[wb_rd] next cycle; simultaneous set and clear of same register -> set wins.
REQ-025 Simultaneous enqueue and issue SHALL leave count unchanged, including when full (in_ready=0 when full; no enqueue).
REQ-026 Latency: entry enqueued in cycle N is presentable at head earliest cycle N+1.
REQ-027 flush SHALL empty queue next cycle (pointers and count to 0); enqueue and issue in flush cycle suppressed; scoreboard unchanged.
REQ-028 out_* data fields are don't-care when out_valid=0 but SHALL not contain X in simulation after reset (entries reset to 0).
REQ-029 Pointers SHALL wrap modulo DEPTH without bubbles.

Reset
REQ-030 On rst: count=0, pointers=0, all busy bits=0, all entries=0; out_valid=0, hazard=0, in_ready=0 during reset cycle, 1 first cycle after.
REQ-031 Reset mid-operation SHALL discard queued entries and scoreboard state with no issue in reset cycle.

Verification
REQ-032 Fill: 5 back-to-back enqueues, out_ready=0, DEPTH=4 -> count=4, in_ready=0, 5th held; then drain in order, PCs preserved.
REQ-033 RAW stall: issue ADDI x5 (busy x5), next ADD x6,x5,x1 -> hazard=1, out_valid=0 until fwd_valid[0], fwd_rd=5, fwd_data=0x1234 -> out_rs1v=0x1234 issued same cycle.
REQ-034 Forward priority: fwd channel0 rd=3 data=0xA, channel1 rd=3 data=0xB -> out_rs1v=0xA.
REQ-035 Set/clear collision: issue LUI x7 while wb_valid wb_rd=7 -> busy[7]=1 next cycle.
REQ-036 Flush: 3 entries queued, flush with in_valid=1 -> count=0 next cycle, no enqueue, scoreboard unchanged.
REQ-037 Unused-source: SW with busy rs2 stalls; LUI with busy inst[19:15] field issues without stall; x0 source reads 0 despite fwd_rd=0.
